// File: rtl/xylo_pkg.sv
// Shared constants, state encoding and the note-to-segment decoder for the xylophone sequencer.
package xylo_pkg;

  localparam int unsigned NOTE_C    = 0;
  localparam int unsigned NOTE_D    = 1;
  localparam int unsigned NOTE_E    = 2;
  localparam int unsigned NOTE_F    = 3;
  localparam int unsigned NOTE_G    = 4;
  localparam int unsigned NOTE_A    = 5;
  localparam int unsigned NOTE_B    = 6;
  localparam int unsigned NUM_NOTES = 7;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_G     = 7'b0111101;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Map a note code to its display pattern; invalid codes show blank.
  function automatic logic [6:0] note_to_seg(input int unsigned code);
    case (code)
      NOTE_C:  note_to_seg = SEG_C;
      NOTE_D:  note_to_seg = SEG_D;
      NOTE_E:  note_to_seg = SEG_E;
      NOTE_F:  note_to_seg = SEG_F;
      NOTE_G:  note_to_seg = SEG_G;
      NOTE_A:  note_to_seg = SEG_A;
      NOTE_B:  note_to_seg = SEG_B;
      default: note_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/xylo_note_fifo.sv
// Synchronous note FIFO with combinational head read and registered occupancy flags.
module xylo_note_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_d;

  assign dout = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // Pointers and flags; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == CW'(0));
    end
  end

endmodule

// File: rtl/xylo_note_sequencer.sv
// Captures note codes into a FIFO with live echo, and replays them with fixed hold and gap timing.
module xylo_note_sequencer
  import xylo_pkg::*;
#(
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned NOTE_CYCLES = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ready,
  input  logic [CODE_W-1:0]          code,
  input  logic                       play,
  input  logic                       clear,
  output logic [6:0]                 seg,
  output logic                       note_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       bad_code
);

  localparam int unsigned TW = $clog2(NOTE_CYCLES+1);

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic [TW-1:0]     timer_q;
  logic [TW-1:0]     timer_d;
  logic [6:0]        seg_d;
  logic              capture_c;
  logic              code_ok_c;
  logic              pop_c;
  logic              push_c;
  logic [CODE_W-1:0] head_c;

  assign capture_c = ready && !ready_q;
  assign code_ok_c = (32'(code) < NUM_NOTES);
  assign pop_c     = !clear && !empty &&
                     (((state_q == ST_IDLE) && play) || (state_q == ST_GAP));
  assign push_c    = !clear && capture_c && code_ok_c && (!full || pop_c);

  xylo_note_fifo #(
    .W     (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push_c),
    .pop   (pop_c),
    .din   (code),
    .dout  (head_c),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (play && !empty) state_d = ST_HOLD;
        ST_HOLD: if (timer_q == TW'(0)) state_d = ST_GAP;
        ST_GAP:  state_d = empty ? ST_IDLE : ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next display pattern and hold timer.
  always_comb begin
    seg_d   = seg;
    timer_d = timer_q;
    if (clear) begin
      seg_d   = SEG_BLANK;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play && !empty) begin
            seg_d   = note_to_seg(32'(head_c));
            timer_d = TW'(NOTE_CYCLES - 1);
          end else if (push_c) begin
            seg_d = note_to_seg(32'(code));
          end
        end
        ST_HOLD: begin
          if (timer_q == TW'(0)) seg_d = SEG_BLANK;
          else                   timer_d = timer_q - TW'(1);
        end
        ST_GAP: begin
          if (!empty) begin
            seg_d   = note_to_seg(32'(head_c));
            timer_d = TW'(NOTE_CYCLES - 1);
          end else begin
            seg_d = SEG_BLANK;
          end
        end
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  // Registered outputs, edge detector and timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q    <= 1'b0;
      timer_q    <= '0;
      seg        <= SEG_BLANK;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bad_code   <= 1'b0;
    end else begin
      ready_q    <= ready;
      timer_q    <= timer_d;
      seg        <= seg_d;
      note_valid <= (state_d == ST_HOLD);
      busy       <= (state_d != ST_IDLE);
      overflow   <= clear ? 1'b0
                  : (overflow || (capture_c && code_ok_c && full && !pop_c));
      bad_code   <= !clear && capture_c && !code_ok_c;
    end
  end

endmodule

// File: tb/tb_xylo_note_sequencer.sv
// Directed bench for xylo_note_sequencer at default parameters.
module tb_xylo_note_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] code  = 4'd0;
  logic       play  = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic       note_valid;
  logic       busy;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       bad_code;

  int checks   = 0;
  int failures = 0;
  logic bad_seen = 1'b0;

  localparam logic [6:0] P_C = 7'b0111001;
  localparam logic [6:0] P_D = 7'b1011110;
  localparam logic [6:0] P_E = 7'b1111001;
  localparam logic [6:0] P_G = 7'b0111101;
  localparam logic [6:0] P_A = 7'b1110111;

  xylo_note_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .code       (code),
    .play       (play),
    .clear      (clear),
    .seg        (seg),
    .note_valid (note_valid),
    .busy       (busy),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .bad_code   (bad_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [3:0] c);
    code  = c;
    ready = 1'b1;
    step();
    bad_seen = bad_seen | bad_code;
    ready = 1'b0;
    step();
    bad_seen = bad_seen | bad_code;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic [6:0] exp_seg [18];

  initial begin
    repeat (2) step();
    reset = 1'b0;
    check("rst_seg", 32'(seg), 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_note_valid", 32'(note_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_bad_code", 32'(bad_code), 0);

    // Echo of C, D, E
    capture(4'd0); capture(4'd1); capture(4'd2);
    check("t1_count", 32'(count), 3);
    check("t1_seg_echo", 32'(seg), 32'(P_E));
    check("t1_bad_never", 32'(bad_seen), 0);

    // Invalid code
    code = 4'd9; ready = 1'b1;
    step();
    check("t2_bad_pulse", 32'(bad_code), 1);
    check("t2_count", 32'(count), 3);
    check("t2_seg", 32'(seg), 32'(P_E));
    ready = 1'b0;
    step();
    check("t2_bad_cleared", 32'(bad_code), 0);

    // Playback of {C, G}
    do_clear();
    check("t3_clear_count", 32'(count), 0);
    check("t3_clear_seg", 32'(seg), 0);
    capture(4'd0); capture(4'd4);
    check("t3_echo_g", 32'(seg), 32'(P_G));
    check("t3_count2", 32'(count), 2);
    for (int i = 0; i < 18; i++) begin
      if (i < 8)       exp_seg[i] = P_C;
      else if (i == 8) exp_seg[i] = 7'd0;
      else if (i < 17) exp_seg[i] = P_G;
      else             exp_seg[i] = 7'd0;
    end
    play = 1'b1;
    step();
    play = 1'b0;
    check("t3_first_busy", 32'(busy), 1);
    check("t3_first_nv", 32'(note_valid), 1);
    check("t3_first_count", 32'(count), 1);
    for (int i = 0; i < 18; i++) begin
      check($sformatf("t3_seg_%0d", i), 32'(seg), 32'(exp_seg[i]));
      if (i == 8)  check("t3_gap_nv", 32'(note_valid), 0);
      if (i == 17) check("t3_gap2_busy", 32'(busy), 1);
      if (i < 17) step();
    end
    step();
    check("t3_idle_busy", 32'(busy), 0);
    check("t3_idle_empty", 32'(empty), 1);
    check("t3_idle_seg", 32'(seg), 0);

    // Fill and overflow
    do_clear();
    for (int i = 0; i < 16; i++) capture(4'(i % 7));
    check("t4_count16", 32'(count), 16);
    check("t4_full", 32'(full), 1);
    check("t4_no_ovf_yet", 32'(overflow), 0);
    capture(4'd3);
    check("t4_overflow", 32'(overflow), 1);
    check("t4_count_held", 32'(count), 16);
    check("t4_full_held", 32'(full), 1);
    do_clear();
    check("t4_clear_count", 32'(count), 0);
    check("t4_clear_ovf", 32'(overflow), 0);
    check("t4_clear_full", 32'(full), 0);
    check("t4_clear_empty", 32'(empty), 1);

    // Held ready gives a single push; play on empty is ignored
    code = 4'd5; ready = 1'b1;
    repeat (5) step();
    ready = 1'b0;
    step();
    check("t5_one_push", 32'(count), 1);
    check("t5_seg_a", 32'(seg), 32'(P_A));
    do_clear();
    play = 1'b1;
    repeat (2) step();
    play = 1'b0;
    check("t5_empty_play_busy", 32'(busy), 0);
    check("t5_empty_play_seg", 32'(seg), 0);

    // Reset during the third hold clock
    capture(4'd1); capture(4'd2);
    play = 1'b1;
    step();
    play = 1'b0;
    check("t6_play_d", 32'(seg), 32'(P_D));
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_seg", 32'(seg), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_nv", 32'(note_valid), 0);

    // Capture during playback is queued behind the current note
    capture(4'd0); capture(4'd4);
    play = 1'b1;
    step();
    play = 1'b0;
    check("t6_c_shown", 32'(seg), 32'(P_C));
    step();
    capture(4'd2);
    check("t6_hold_seg_kept", 32'(seg), 32'(P_C));
    check("t6_queued_count", 32'(count), 2);
    repeat (5) step();
    check("t6_gap1", 32'(seg), 0);
    step();
    check("t6_g_shown", 32'(seg), 32'(P_G));
    check("t6_g_count", 32'(count), 1);
    repeat (8) step();
    check("t6_gap2", 32'(seg), 0);
    step();
    check("t6_e_shown", 32'(seg), 32'(P_E));
    check("t6_e_count", 32'(count), 0);
    repeat (8) step();
    check("t6_gap3", 32'(seg), 0);
    check("t6_gap3_busy", 32'(busy), 1);
    step();
    check("t6_end_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
